// File: rtl/reg_bank_pkg.sv
// reg_bank shared definitions
// Operation encodings and architectural register indices.
package reg_bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_XFER = 3'd4,
        OP_PUSH = 3'd5,
        OP_POP  = 3'd6
    } op_t;

    localparam int REG_A = 0;
    localparam int REG_X = 1;
    localparam int REG_Y = 2;
    localparam int REG_S = 3;

endpackage

// File: rtl/reg_bank_cell.sv
// Single architectural register
// Async active-high reset to RESET_VAL, loads d when en is high.
module reg_cell #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register storage with load enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// CPU register bank: A/X/Y/S with inc/dec, transfer, push/pop
// Single write port per cycle; N/Z flags and pulses are registered.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               NREGS    = 4,
    parameter int               SP_INDEX = 3,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(8'hFF),
    localparam int              SELW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  dst_sel,
    input  logic [SELW-1:0]  src_sel,
    input  logic [WIDTH-1:0] in,
    input  logic [SELW-1:0]  rd_sel_a,
    input  logic [SELW-1:0]  rd_sel_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] sp_addr,
    output logic             n_flag,
    output logic             z_flag,
    output logic             flag_upd,
    output logic             sp_wrap
);

    localparam logic [SELW-1:0] SP_SEL = SELW'(SP_INDEX);

    logic [WIDTH-1:0] q [NREGS];
    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] dst_val;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] wr_data;
    logic [SELW-1:0]  wr_idx;
    logic             wr_en;
    logic             flag_en;
    logic             wrap;
    logic             dst_ok;
    logic             src_ok;
    logic             ra_ok;
    logic             rb_ok;

    // Selects beyond NREGS only exist when NREGS is not a power of two
    if (NREGS == (1 << SELW)) begin : g_full
        assign dst_ok = 1'b1;
        assign src_ok = 1'b1;
        assign ra_ok  = 1'b1;
        assign rb_ok  = 1'b1;
    end else begin : g_part
        assign dst_ok = int'(dst_sel) < NREGS;
        assign src_ok = int'(src_sel) < NREGS;
        assign ra_ok  = int'(rd_sel_a) < NREGS;
        assign rb_ok  = int'(rd_sel_b) < NREGS;
    end

    assign s_val   = q[SP_INDEX];
    assign dst_val = dst_ok ? q[dst_sel] : '0;
    assign src_val = src_ok ? q[src_sel] : '0;
    assign out_a   = ra_ok ? q[rd_sel_a] : '0;
    assign out_b   = rb_ok ? q[rd_sel_b] : '0;

    // Decode op into one register write, stack address and wrap
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = dst_sel;
        wr_data = dst_val;
        wrap    = 1'b0;
        sp_addr = s_val;
        case (op)
            OP_LOAD: begin
                wr_en   = dst_ok;
                wr_data = in;
            end
            OP_INC: begin
                wr_en   = dst_ok;
                wr_data = dst_val + WIDTH'(1);
            end
            OP_DEC: begin
                wr_en   = dst_ok;
                wr_data = dst_val - WIDTH'(1);
            end
            OP_XFER: begin
                wr_en   = dst_ok && src_ok;
                wr_data = src_val;
            end
            OP_PUSH: begin
                wr_en   = 1'b1;
                wr_idx  = SP_SEL;
                wr_data = s_val - WIDTH'(1);
                wrap    = (s_val == '0);
            end
            OP_POP: begin
                wr_en   = 1'b1;
                wr_idx  = SP_SEL;
                wr_data = s_val + WIDTH'(1);
                sp_addr = s_val + WIDTH'(1);
                wrap    = (s_val == '1);
            end
            default: ;
        endcase
        // Stack writes, including TXS-style transfers, keep the flags
        flag_en = wr_en && (wr_idx != SP_SEL);
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        reg_cell #(
            .WIDTH    (WIDTH),
            .RESET_VAL(i == SP_INDEX ? SP_RESET : '0)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .en (wr_en && (wr_idx == SELW'(i))),
            .d  (wr_data),
            .q  (q[i])
        );
    end

    // Registered flags and one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_flag   <= 1'b0;
            z_flag   <= 1'b1;
            flag_upd <= 1'b0;
            sp_wrap  <= 1'b0;
        end else begin
            flag_upd <= flag_en;
            sp_wrap  <= wrap;
            if (flag_en) begin
                n_flag <= wr_data[WIDTH-1];
                z_flag <= (wr_data == '0);
            end
        end
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised CPU register bank that generalises the single byte register into NREGS architectural registers (A, X, Y, S by default) with in-place increment/decrement, register-to-register transfer, stack-pointer push/pop sequencing, and registered N/Z flag generation. It sits between the decode/control unit and the ALU/address path: control issues one operation per cycle; the ALU and address mux read through two combinational ports. The stack-address output feeds the page-1 address generator.

## Interface
- WIDTH, 8: register width in bits
- NREGS, 4: number of registers (index 0 = A, 1 = X, 2 = Y, 3 = S)
- SP_INDEX, 3: index of the stack-pointer register
- SP_RESET, 8'hFF: reset value of the stack pointer (other registers reset to 0)
- SELW, $clog2(NREGS): register-select width (derived, not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  3  operation: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 XFER, 5 PUSH, 6 POP
- dst_sel  input  SELW  destination register for LOAD/INC/DEC/XFER
- src_sel  input  SELW  source register for XFER
- in  input  WIDTH  load data for LOAD
- rd_sel_a, rd_sel_b  input  SELW  read-port selects
- out_a, out_b  output  WIDTH  combinational read data
- sp_addr  output  WIDTH  stack address for the current cycle (see Operation)
- n_flag, z_flag  output  1  registered negative/zero flags
- flag_upd  output  1  one-cycle pulse: n_flag/z_flag were just updated
- sp_wrap  output  1  one-cycle pulse: stack pointer wrapped

## Operation
- Reset (async, immediate): regs = 0 except reg[SP_INDEX] = SP_RESET; n_flag = 0, z_flag = 1, flag_upd = 0, sp_wrap = 0.
- LOAD: reg[dst_sel] <= in.
- INC/DEC: reg[dst_sel] <= reg[dst_sel] ± 1, modulo 2^WIDTH; no carry out.
- XFER: reg[dst_sel] <= reg[src_sel]; src == dst is legal (value unchanged, flags still update).
- PUSH: S <= S − 1; sp_addr = S (pre-decrement value, i.e. the write slot). dst_sel ignored.
- POP: S <= S + 1; sp_addr = S + 1 (post-increment value, i.e. the read slot). dst_sel ignored.
- Other ops: sp_addr = S.
- Flags: LOAD, INC, DEC, XFER with dst_sel != SP_INDEX set n_flag = result[WIDTH−1], z_flag = (result == 0), flag_upd = 1. Writes to S (incl. TXS-style XFER), PUSH, POP, NOP leave flags unchanged, flag_upd = 0.
- sp_wrap = 1 on PUSH when S == 0 or POP when S == all-ones; S wraps modulo 2^WIDTH.
- dst_sel/src_sel/rd_sel ≥ NREGS: op treated as NOP (no write, no flag update); read returns 0.
- Op codes 7: NOP.

## Timing
- Write latency 1 cycle: result visible on out_a/out_b the cycle after op is sampled; no write-to-read bypass (same-cycle read returns old value).
- Flags, flag_upd, sp_wrap are registered: valid the cycle after the op, same edge as the register update.
- sp_addr combinational from current S and op.
- Reset asserted mid-stream: all state cleared at reset assertion; first op honoured on the first rising edge with rst low.

## Structure
- Package reg_bank_pkg: op enum (OP_NOP … OP_POP), register index constants (REG_A, REG_X, REG_Y, REG_S).
- Sub-module reg_cell (WIDTH, RESET_VAL): one register with async active-high reset and load enable; instantiated NREGS times via generate. Next-value mux, flag logic and sp_addr in reg_bank.

## Test plan
- Reset: assert rst -> A=X=Y=0, S=8'hFF, z_flag=1, n_flag=0 while rst high, without a clock edge.
- LOAD A=8'h80 then INC A -> A=8'h81 next cycle; n=1,z=0, flag_upd pulses once per op.
- LOAD X=8'hFF, INC X -> X=8'h00, z=1, n=0; DEC X -> X=8'hFF, n=1.
- XFER X->S with X=8'h10 -> S=8'h10, flags unchanged, flag_upd=0; PUSH -> sp_addr=8'h10, S=8'h0F; POP -> sp_addr=8'h10, S=8'h10.
- S=8'h00, PUSH -> sp_addr=8'h00, S=8'hFF, sp_wrap=1; POP -> sp_addr=8'h00, S=8'h00, sp_wrap=1.
- Reset asserted between LOAD and following INC -> A=0 after reset, INC after release yields A=1.
